// File: rtl/ibis_pkg.sv
// ibis_pkg: shared types and helpers for the Ibis forward-mapper texel loader.
package ibis_pkg;

   localparam int TEXEL_W = 9;

   typedef logic [TEXEL_W-1:0] texel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } loader_state_t;

   // Number of texels in a square tile whose edge is 1 << pow2.
   function automatic int tile_texels(input int pow2);
      return 1 << (2 * pow2);
   endfunction

endpackage

// File: rtl/ibis_frame_tracker.sv
// ibis_frame_tracker: follows the mapper's 10-stage frame and flags frame boundaries.
module ibis_frame_tracker (
   input  logic aclk,
   input  logic aresetn,
   input  logic enable,
   input  logic cycle_complete,
   output logic r_at_stage0,
   output logic frame_boundary
);

   assign frame_boundary = enable && cycle_complete;

   // The mapper leaves reset at stage 0 and enters stage 0 after every stage-9 cycle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         r_at_stage0 <= 1'b1;
      else if (enable)
         r_at_stage0 <= cycle_complete;
   end

endmodule

// File: rtl/ibis_texel_loader.sv
// ibis_texel_loader: streams one tile of texels into the mapper, one texel per frame.
// Define IBIS_TEXEL_LOADER_TLAST_CHECK_EN to flag s_tlast placement errors on error.
module ibis_texel_loader
   import ibis_pkg::*;
#(
   parameter int TILE_SIZE_POW2 = 5
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        enable,
   input  logic                        cycle_complete,
   input  logic                        start,
   input  logic [TEXEL_W-1:0]          s_tdata,
   input  logic                        s_tvalid,
   output logic                        s_tready,
   input  logic                        s_tlast,
   output logic                        write_texels,
   output logic [2*TILE_SIZE_POW2-1:0] texel_address,
   output logic [TEXEL_W-1:0]          texel_data,
   output logic                        busy,
   output logic                        done,
   output logic                        error
);

   localparam int AW = 2 * TILE_SIZE_POW2;
   localparam int CW = AW + 1;
   localparam int N  = tile_texels(TILE_SIZE_POW2);
   localparam logic [CW-1:0] LAST  = CW'(N - 1);
   localparam logic [CW-1:0] TOTAL = CW'(N);

   loader_state_t   state;
   logic [CW-1:0]   counter;
   logic            hold_valid;
   texel_t          hold_data;
   logic            frame_boundary;
   logic            unused_at_stage0;
   logic            accept;
   logic            transfer;

   ibis_frame_tracker u_frame (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .enable         (enable),
      .cycle_complete (cycle_complete),
      .r_at_stage0    (unused_at_stage0),
      .frame_boundary (frame_boundary)
   );

   assign s_tready = (state == LOAD) && !hold_valid && (counter < TOTAL);
   assign accept   = s_tvalid && s_tready;
   assign transfer = frame_boundary && (state == LOAD) && hold_valid;
   assign busy     = (state != IDLE);

   // Upload sequencer: outputs only move on frame boundaries so the mapper sees them stable for a whole frame.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= IDLE;
         counter       <= '0;
         hold_valid    <= 1'b0;
         hold_data     <= '0;
         write_texels  <= 1'b0;
         texel_address <= '0;
         texel_data    <= '0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            hold_valid <= 1'b1;
            hold_data  <= s_tdata;
         end else if (transfer) begin
            hold_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= LOAD;
                  counter <= '0;
               end
            end
            LOAD: begin
               if (frame_boundary) begin
                  write_texels <= hold_valid;
                  if (hold_valid) begin
                     texel_data    <= hold_data;
                     texel_address <= counter[AW-1:0];
                     counter       <= counter + 1'b1;
                     if (counter == LAST)
                        state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (frame_boundary) begin
                  write_texels <= 1'b0;
                  done         <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IBIS_TEXEL_LOADER_TLAST_CHECK_EN
   logic hold_last;

   // Remember the tlast that travelled with the buffered texel.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         hold_last <= 1'b0;
      else if (accept)
         hold_last <= s_tlast;
   end

   // Sticky flag: tlast must be set on the final texel and on no other.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         error <= 1'b0;
      else if ((state == IDLE) && start)
         error <= 1'b0;
      else if (transfer && (hold_last != (counter == LAST)))
         error <= 1'b1;
   end
`else
   logic unused_tlast;

   assign unused_tlast = s_tlast;
   assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_ibis_texel_loader.sv
// tb_ibis_texel_loader: table-driven and randomized checks of the texel loader against a mapper model.
module tb_ibis_texel_loader;

   localparam int P = 2;
   localparam int N = 16;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       enable = 1'b1;
   logic       cycle_complete = 1'b0;
   logic       start = 1'b0;
   logic [8:0] s_tdata = '0;
   logic       s_tvalid = 1'b0;
   logic       s_tready;
   logic       s_tlast = 1'b0;
   logic       write_texels;
   logic [3:0] texel_address;
   logic [8:0] texel_data;
   logic       busy;
   logic       done;
   logic       error;

   ibis_texel_loader #(.TILE_SIZE_POW2(P)) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .enable         (enable),
      .cycle_complete (cycle_complete),
      .start          (start),
      .s_tdata        (s_tdata),
      .s_tvalid       (s_tvalid),
      .s_tready       (s_tready),
      .s_tlast        (s_tlast),
      .write_texels   (write_texels),
      .texel_address  (texel_address),
      .texel_data     (texel_data),
      .busy           (busy),
      .done           (done),
      .error          (error)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      string name;
      bit    rnd_data;
      bit    rnd_gaps;
      int    stall_idx;
      int    stall_len;
      int    en_off;
      bit    start_mid;
      int    last_idx;
      int    rst_at;
      int    idle_min;
      int    idle_max;
      int    exp_frame;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;

   int stage = 0;
   int cyc = 0;
   int idx, wr_cnt, idle, max_frame, last_bnd, done_cnt;
   int stall_at, stall_len, stall_cnt;
   bit stall_on;
   logic [8:0] sent [N];
   logic [8:0] mem [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock with the mapper/memory model updated from the pre-edge view of the DUT.
   task automatic tick();
      logic       bnd, pw, commit;
      logic [3:0] pa;
      logic [8:0] pd;
      bnd    = enable && cycle_complete;
      pw     = write_texels;
      pa     = texel_address;
      pd     = texel_data;
      commit = bnd && pw;
      if (commit) begin
         chk("wr_addr", 32'(pa), 32'(wr_cnt));
         chk("wr_data", 32'(pd), 32'(sent[wr_cnt % N]));
         mem[pa] = pd;
         wr_cnt++;
      end
      if (bnd && !pw && busy && wr_cnt > 0)
         idle++;
      if (bnd) begin
         if (last_bnd >= 0 && cyc - last_bnd > max_frame)
            max_frame = cyc - last_bnd;
         last_bnd = cyc;
      end
      if (s_tvalid && s_tready) begin
         if (idx == stall_at)
            stall_cnt = stall_len;
         idx++;
      end
      @(posedge aclk);
      #1;
      cyc++;
      if (!bnd)
         chk("stable", {18'd0, pw, pa, pd}, {18'd0, write_texels, texel_address, texel_data});
      chk("done", 32'(done), 32'(commit && wr_cnt == N));
      if (done)
         done_cnt++;
      if (enable)
         stage = (stage == 9) ? 0 : stage + 1;
      cycle_complete = (stage == 9);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_outs"}, {26'd0, write_texels, busy, done, error, s_tready, 1'b0},
          32'd0);
      chk({name, "_addr_data"}, {19'd0, texel_address, texel_data}, 32'd0);
   endtask

   task automatic run(input vec_t v);
      bit en_used = 0, sm_used = 0, hold, gap, exp_err, pulsed;
      int en_left = 0;
      for (int i = 0; i < N; i++) begin
         sent[i] = v.rnd_data ? 9'($urandom) : 9'(i);
         mem[i]  = 'x;
      end
      idx = 0; wr_cnt = 0; idle = 0; max_frame = 0; last_bnd = -1; done_cnt = 0;
      stall_at = v.stall_idx; stall_len = v.stall_len; stall_cnt = 0; stall_on = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({v.name, "_start_busy"}, 32'(busy), 32'd1);
      chk({v.name, "_start_err"}, 32'(error), 32'd0);
      for (int c = 0; c < 1500 && done_cnt == 0; c++) begin
         if (v.rst_at >= 0 && write_texels && texel_address == 4'(v.rst_at)) begin
            #3 aresetn = 1'b0;
            #1 chk_zero({v.name, "_async"});
            @(posedge aclk);
            @(posedge aclk);
            #3 aresetn = 1'b1;
            s_tvalid = 1'b0; start = 1'b0; enable = 1'b1;
            stage = 0; cycle_complete = 1'b0;
            @(posedge aclk);
            #1;
            return;
         end
         if (v.en_off >= 0 && !en_used && wr_cnt == v.en_off && stage == 3) begin
            en_used = 1;
            en_left = 7;
         end
         enable = (en_left == 0);
         if (en_left == 1)
            chk({v.name, "_tready_en_low"}, 32'(s_tready), 32'd0);
         if (en_left > 0)
            en_left--;
         hold = 0;
         if (stall_cnt > 0 && (stall_on || s_tready)) begin
            stall_on = 1;
            stall_cnt--;
            hold = 1;
         end else begin
            stall_on = 0;
         end
         gap      = v.rnd_gaps && ($urandom_range(0, 2) == 0);
         s_tvalid = (idx < N) && !hold && !gap;
         s_tdata  = sent[idx % N];
         s_tlast  = (idx == v.last_idx);
         pulsed   = v.start_mid && !sm_used && wr_cnt == 7;
         if (pulsed)
            sm_used = 1;
         start = pulsed;
         tick();
         start = 1'b0;
         if (pulsed)
            chk({v.name, "_start_ignored"}, 32'(busy), 32'd1);
      end
      s_tvalid = 1'b0;
      enable   = 1'b1;
`ifdef IBIS_TEXEL_LOADER_TLAST_CHECK_EN
      exp_err = (v.last_idx != N - 1);
`else
      exp_err = 0;
`endif
      chk({v.name, "_done_cnt"}, 32'(done_cnt), 32'd1);
      chk({v.name, "_writes"}, 32'(wr_cnt), 32'(N));
      chk({v.name, "_busy_end"}, 32'(busy), 32'd0);
      chk({v.name, "_error"}, 32'(error), 32'(exp_err));
      chk({v.name, "_idle"}, 32'(idle >= v.idle_min && idle <= v.idle_max), 32'd1);
      chk({v.name, "_frame_len"}, 32'(max_frame), 32'(v.exp_frame));
      for (int i = 0; i < N; i++)
         chk({v.name, "_mem"}, 32'(mem[i]), 32'(sent[i]));
      repeat (3) tick();
   endtask

   vec_t vt [10];

   initial begin
      vt[0] = '{"stream",  0, 0, -1,  0, -1, 0, 15, -1, 0,    0, 10};
      vt[1] = '{"stall",   0, 0,  4, 25, -1, 0, 15, -1, 2,    3, 10};
      vt[2] = '{"en_low",  1, 0, -1,  0,  6, 0, 15, -1, 0,    0, 17};
      vt[3] = '{"busy_st", 1, 0, -1,  0, -1, 1, 15, -1, 0,    0, 10};
      vt[4] = '{"tlast3",  0, 0, -1,  0, -1, 0,  3, -1, 0,    0, 10};
      vt[5] = '{"clr_err", 1, 0, -1,  0, -1, 0, 15, -1, 0,    0, 10};
      vt[6] = '{"rnd_a",   1, 1, -1,  0, -1, 0, 15, -1, 0, 1000, 10};
      vt[7] = '{"rnd_b",   1, 1,  9,  7, -1, 0, 15, -1, 0, 1000, 10};
      vt[8] = '{"reset9",  0, 0, -1,  0, -1, 0, 15,  9, 0,    0, 10};
      vt[9] = '{"restart", 0, 0, -1,  0, -1, 0, 15, -1, 0,    0, 10};
      repeat (3) @(posedge aclk);
      #1;
      chk_zero("reset");
      #2 aresetn = 1'b1;
      @(posedge aclk);
      #1;
      for (int i = 0; i < 10; i++)
         run(vt[i]);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
